fixed_point_seq_divider: RTL and testbench

- Parametrised, iterative signed/unsigned fixed-point divider for the raycaster datapath, e.g. wall height = scale / perpendicular distance.
- Computes q = (a << FRAC_W) / b, with a, b and q all in the same Qm.f format.
- Uses one restoring radix-2 step per clock, so arbitrary operand widths close timing.
- Has a valid/ready handshake on both sides, and saturates with status flags on overflow and divide-by-zero.

---
 rtl/fixed_point_seq_divider_if.sv | 25 ++
 rtl/fixed_point_seq_divider.sv | 144 ++++++++++++++
 tb/tb_fixed_point_seq_divider.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/fixed_point_seq_divider_if.sv
// Operand/result handshake bundle for the sequential fixed-point divider.
// The master side supplies operands and accepts results; the divider is the slave.
interface fixed_point_seq_divider_if #(
  parameter int W = 17
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic         overflow;
  logic         div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, overflow, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, overflow, div_by_zero
  );
endinterface

// File: rtl/fixed_point_seq_divider.sv
// Iterative Qm.f divider: q = (a << FRAC_W) / b, one restoring radix-2 step per clock,
// with magnitude/sign split, saturation and divide-by-zero reporting.
module fixed_point_seq_divider #(
  parameter int INT_W  = 10,
  parameter int FRAC_W = 7,
  parameter bit SIGNED = 1'b1
) (
  input logic                  clock,
  input logic                  resetn,
  fixed_point_seq_divider_if.slave bus
);
  localparam int W     = INT_W + FRAC_W;
  localparam int N     = W + FRAC_W;
  localparam int CNT_W = $clog2(N);

  localparam logic [W-1:0] MAX_POS = SIGNED ? {1'b0, {(W-1){1'b1}}} : {W{1'b1}};
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};
  localparam logic [N-1:0] POS_LIM = {{FRAC_W{1'b0}}, MAX_POS};
  localparam logic [N-1:0] NEG_LIM = {{FRAC_W{1'b0}}, MIN_NEG};

  typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

  state_t             state, state_nxt;
  logic [W-1:0]       a_q, b_q;
  logic [W-1:0]       bmag;
  logic [W-1:0]       rem;
  logic [N-1:0]       shreg;
  logic [CNT_W-1:0]   cnt;
  logic               a_neg, res_neg, bzero;
  logic [W-1:0]       quot_reg;
  logic               ovf_reg, dbz_reg, out_vld;

  logic [W:0]         rem_sh;
  logic [W-1:0]       diff;
  logic               ge;

  // Unsigned W-bit magnitude; -2^(W-1) maps onto 2^(W-1) without wrapping.
  function automatic logic [W-1:0] magnitude(input logic [W-1:0] v);
    if (SIGNED && v[W-1]) return $unsigned(-$signed(v));
    return v;
  endfunction

  // Returns {overflow, quotient} for a quotient magnitude and result sign.
  function automatic logic [W:0] saturate(input logic [N-1:0] mag, input logic neg);
    logic [W-1:0] low;
    low = mag[W-1:0];
    if (neg) begin
      if (mag > NEG_LIM) return {1'b1, MIN_NEG};
      return {1'b0, $unsigned(-$signed(low))};
    end
    if (mag > POS_LIM) return {1'b1, MAX_POS};
    return {1'b0, low};
  endfunction

  function automatic logic [W-1:0] div0_value(input logic neg);
    return neg ? MIN_NEG : MAX_POS;
  endfunction

  assign bus.in_ready    = (state == IDLE);
  assign bus.out_valid   = out_vld;
  assign bus.quotient    = quot_reg;
  assign bus.overflow    = ovf_reg;
  assign bus.div_by_zero = dbz_reg;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nxt = PREP;
      PREP:    state_nxt = (b_q == '0) ? FIX : ITER;
      ITER:    if (cnt == '0) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Restoring step: the remainder stays below |b|, so the W-bit difference is exact.
  always_comb begin
    rem_sh = {rem, shreg[N-1]};
    ge     = (rem_sh >= {1'b0, bmag});
    diff   = rem_sh[W-1:0] - bmag;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      a_q      <= '0;
      b_q      <= '0;
      bmag     <= '0;
      rem      <= '0;
      shreg    <= '0;
      cnt      <= '0;
      a_neg    <= 1'b0;
      res_neg  <= 1'b0;
      bzero    <= 1'b0;
      quot_reg <= '0;
      ovf_reg  <= 1'b0;
      dbz_reg  <= 1'b0;
      out_vld  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q <= bus.dividend;
            b_q <= bus.divisor;
          end
        end
        PREP: begin
          a_neg   <= SIGNED && a_q[W-1];
          res_neg <= SIGNED && (a_q[W-1] ^ b_q[W-1]);
          bzero   <= (b_q == '0);
          bmag    <= magnitude(b_q);
          rem     <= '0;
          shreg   <= {magnitude(a_q), {FRAC_W{1'b0}}};
          cnt     <= CNT_W'(N - 1);
        end
        ITER: begin
          rem   <= ge ? diff : rem_sh[W-1:0];
          shreg <= {shreg[N-2:0], ge};
          cnt   <= cnt - CNT_W'(1);
        end
        FIX: begin
          if (bzero) begin
            quot_reg <= div0_value(a_neg);
            ovf_reg  <= 1'b0;
            dbz_reg  <= 1'b1;
          end else begin
            {ovf_reg, quot_reg} <= saturate(shreg, res_neg);
            dbz_reg             <= 1'b0;
          end
          out_vld <= 1'b1;
        end
        DONE: begin
          if (bus.out_ready) out_vld <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fixed_point_seq_divider.sv
// Directed bench: signed Q10.7 and unsigned Q8.8 dividers against an integer-arithmetic model.
module tb_fixed_point_seq_divider;
  logic clock = 1'b0;
  logic resetn = 1'b1;
  always #5 clock = ~clock;

  fixed_point_seq_divider_if #(.W(17)) s_if ();
  fixed_point_seq_divider_if #(.W(16)) u_if ();

  fixed_point_seq_divider #(.INT_W(10), .FRAC_W(7), .SIGNED(1'b1)) dut_s (
    .clock(clock), .resetn(resetn), .bus(s_if));
  fixed_point_seq_divider #(.INT_W(8), .FRAC_W(8), .SIGNED(1'b0)) dut_u (
    .clock(clock), .resetn(resetn), .bus(u_if));

  typedef struct packed {
    logic        dbz;
    logic        ovf;
    logic [16:0] q;
  } exp_t;

  exp_t s_exp[$];
  exp_t u_exp[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Result straight from the arithmetic definition: exact division, truncation, clamp.
  function automatic exp_t model(input logic [16:0] ra, input logic [16:0] rb,
                                 input int iw, input int fw, input bit sgn);
    int     w;
    longint a, b, r, maxv, minv;
    exp_t   e;
    w = iw + fw;
    a = longint'(ra);
    b = longint'(rb);
    if (sgn && ra[w-1]) a = a - (longint'(1) << w);
    if (sgn && rb[w-1]) b = b - (longint'(1) << w);
    maxv = sgn ? (longint'(1) << (w - 1)) - 1 : (longint'(1) << w) - 1;
    minv = sgn ? -(longint'(1) << (w - 1)) : 0;
    e = '0;
    if (b == 0) begin
      e.dbz = 1'b1;
      r = (a < 0) ? minv : maxv;
    end else begin
      r = (a * (longint'(1) << fw)) / b;
      if (r > maxv) begin r = maxv; e.ovf = 1'b1; end
      else if (r < minv) begin r = minv; e.ovf = 1'b1; end
    end
    e.q = 17'(r & ((longint'(1) << w) - 1));
    return e;
  endfunction

  function automatic logic rdy(input bit u);
    return u ? u_if.in_ready : s_if.in_ready;
  endfunction

  function automatic logic ov(input bit u);
    return u ? u_if.out_valid : s_if.out_valid;
  endfunction

  task automatic drive_in(input bit u, input logic v, input logic [16:0] a, input logic [16:0] b);
    if (u) begin
      u_if.in_valid = v; u_if.dividend = a[15:0]; u_if.divisor = b[15:0];
    end else begin
      s_if.in_valid = v; s_if.dividend = a; s_if.divisor = b;
    end
  endtask

  task automatic push_exp(input bit u, input exp_t e);
    if (u) u_exp.push_back(e);
    else   s_exp.push_back(e);
  endtask

  task automatic wait_out(input bit u, input int exp_lat, input string tag);
    int n;
    n = 0;
    while (!ov(u) && n < 100) begin @(posedge clock); #1; n++; end
    check({tag, "_latency"}, longint'(n), longint'(exp_lat));
  endtask

  // One full transaction with out_ready held high.
  task automatic run(input bit u, input logic [16:0] a, input logic [16:0] b,
                     input logic [16:0] lq, input logic lovf, input logic ldbz,
                     input int exp_lat, input string tag);
    exp_t e;
    int   n;
    e = model(a, b, u ? 8 : 10, u ? 8 : 7, !u);
    check({tag, "_model"}, longint'(e), longint'({ldbz, lovf, lq}));
    drive_in(u, 1'b1, a, b);
    n = 0;
    while (!rdy(u) && n < 100) begin @(posedge clock); #1; n++; end
    check({tag, "_in_ready_idle"}, longint'(rdy(u)), 1);
    @(posedge clock);
    push_exp(u, e);
    #1 drive_in(u, 1'b0, a, b);
    check({tag, "_in_ready_busy"}, longint'(rdy(u)), 0);
    wait_out(u, exp_lat, tag);
    @(posedge clock); #1;
    check({tag, "_in_ready_after"}, longint'(rdy(u)), 1);
    check({tag, "_out_valid_after"}, longint'(ov(u)), 0);
  endtask

  // Scoreboard compare on every cycle a result is presented.
  always @(negedge clock) begin
    if (resetn && s_if.out_valid) begin
      if (s_exp.size() == 0) begin
        checks++; errors++;
        $display("FAIL s_unexpected_result: got 0x%0h, expected no result", s_if.quotient);
      end else begin
        check("s_result", longint'({s_if.div_by_zero, s_if.overflow, s_if.quotient}),
              longint'(s_exp[0]));
        if (s_if.out_ready) void'(s_exp.pop_front());
      end
    end
    if (resetn && u_if.out_valid) begin
      if (u_exp.size() == 0) begin
        checks++; errors++;
        $display("FAIL u_unexpected_result: got 0x%0h, expected no result", u_if.quotient);
      end else begin
        check("u_result", longint'({u_if.div_by_zero, u_if.overflow, 1'b0, u_if.quotient}),
              longint'(u_exp[0]));
        if (u_if.out_ready) void'(u_exp.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e1, e2;
    drive_in(1'b0, 1'b0, 17'd0, 17'd0);
    drive_in(1'b1, 1'b0, 17'd0, 17'd0);
    s_if.out_ready = 1'b1;
    u_if.out_ready = 1'b1;
    #2 resetn = 1'b0;
    #1;
    check("rst_out_valid", longint'(s_if.out_valid), 0);
    check("rst_quotient", longint'(s_if.quotient), 0);
    check("rst_flags", longint'({s_if.overflow, s_if.div_by_zero}), 0);
    check("rst_in_ready", longint'(s_if.in_ready), 1);
    repeat (3) @(posedge clock);
    #1 resetn = 1'b1;

    run(1'b0, 17'd384, 17'd192, 17'd256, 1'b0, 1'b0, 26, "basic");
    run(1'b0, 17'(-640), 17'd256, 17'(-320), 1'b0, 1'b0, 26, "neg");
    run(1'b0, 17'd128, 17'd384, 17'd42, 1'b0, 1'b0, 26, "trunc_pos");
    run(1'b0, 17'(-128), 17'd384, 17'(-42), 1'b0, 1'b0, 26, "trunc_neg");
    run(1'b0, 17'd65408, 17'd1, 17'h0FFFF, 1'b1, 1'b0, 26, "ovf_pos");
    run(1'b0, 17'h10000, 17'd128, 17'h10000, 1'b0, 1'b0, 26, "min_exact");
    run(1'b0, 17'h10000, 17'(-128), 17'h0FFFF, 1'b1, 1'b0, 26, "min_ovf");
    run(1'b0, 17'(-128), 17'd0, 17'h10000, 1'b0, 1'b1, 2, "dbz_neg");
    run(1'b0, 17'd0, 17'd0, 17'h0FFFF, 1'b0, 1'b1, 2, "dbz_zero");

    // Backpressure: result held, stray in_valid pulses ignored, queued pair waits.
    e1 = model(17'd896, 17'd256, 10, 7, 1'b1);
    check("bp_model", longint'(e1), longint'({2'b00, 17'd448}));
    s_if.out_ready = 1'b0;
    drive_in(1'b0, 1'b1, 17'd896, 17'd256);
    check("bp_in_ready_idle", longint'(s_if.in_ready), 1);
    @(posedge clock);
    push_exp(1'b0, e1);
    #1 drive_in(1'b0, 1'b0, 17'd896, 17'd256);
    wait_out(1'b0, 26, "bp");
    for (int i = 0; i < 5; i++) begin
      drive_in(1'b0, (i % 2) == 0, 17'd128, 17'd128);
      @(posedge clock); #1;
      check("bp_in_ready_held", longint'(s_if.in_ready), 0);
      check("bp_out_valid_held", longint'(s_if.out_valid), 1);
    end
    e2 = model(17'd128, 17'd384, 10, 7, 1'b1);
    drive_in(1'b0, 1'b1, 17'd128, 17'd384);
    s_if.out_ready = 1'b1;
    @(posedge clock); #1;
    check("bp_in_ready_after_xfer", longint'(s_if.in_ready), 1);
    check("bp_out_valid_after_xfer", longint'(s_if.out_valid), 0);
    push_exp(1'b0, e2);
    @(posedge clock);
    #1 drive_in(1'b0, 1'b0, 17'd128, 17'd384);
    check("bp_queued_accepted", longint'(s_if.in_ready), 0);
    wait_out(1'b0, 26, "bp_queued");
    @(posedge clock); #1;

    // Reset during ITER aborts the operation and clears the result.
    drive_in(1'b0, 1'b1, 17'd384, 17'd192);
    @(posedge clock);
    #1 drive_in(1'b0, 1'b0, 17'd384, 17'd192);
    repeat (10) @(posedge clock);
    #1 resetn = 1'b0;
    #1;
    check("abort_out_valid", longint'(s_if.out_valid), 0);
    check("abort_quotient", longint'(s_if.quotient), 0);
    check("abort_flags", longint'({s_if.overflow, s_if.div_by_zero}), 0);
    check("abort_in_ready", longint'(s_if.in_ready), 1);
    s_exp.delete();
    @(posedge clock);
    #1 resetn = 1'b1;
    run(1'b0, 17'd384, 17'd192, 17'd256, 1'b0, 1'b0, 26, "post_reset");

    run(1'b1, 17'h0FF00, 17'h00200, 17'h07F80, 1'b0, 1'b0, 26, "u_half");
    run(1'b1, 17'h0FF00, 17'h00080, 17'h0FFFF, 1'b1, 1'b0, 26, "u_ovf");

    repeat (3) @(posedge clock); #1;
    check("s_queue_drained", longint'(s_exp.size()), 0);
    check("u_queue_drained", longint'(u_exp.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
